serial_char_receiver: RTL and testbench

Receive side of the chip's serial character link: an 8N1, LSB-first, asynchronous serial receiver that recovers the character stream sent by the transmitter design.
- Oversamples `rx` at a fixed clocks-per-bit ratio.
- Buffers accepted characters in a small show-ahead FIFO.
- Reports a received-character count, a state code and sticky error flags.
- Lets a loopback bench check transmitter output character by character.

---
 rtl/serial_char_receiver_pkg.sv | 17 +
 rtl/serial_char_receiver_char_fifo.sv | 81 ++++++++
 rtl/serial_char_receiver.sv | 161 ++++++++++++++++
 tb/tb_serial_char_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_char_receiver_pkg.sv
// Shared definitions for the serial character link (receiver side).
// Holds the FSM state encoding, the frame data width and the default
// bit period.  The transmitter uses the same bit period constant.
package serial_char_receiver_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // Encoding is visible on which_state, so the values are fixed.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_DATA  = 4'd2,
        ST_STOP  = 4'd3
    } state_e;

endpackage

// File: rtl/serial_char_receiver_char_fifo.sv
// char_fifo: synchronous show-ahead FIFO for received characters.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push_i/_data_i  write request and data (dropped when full without pop)
//   pop_i           remove head (ignored when empty)
//   rd_data_o       registered head; holds last value when empty
//   full_o, empty_o status
//   count_o         entries held
module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign do_pop     = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push    = push_i && (!full_o || do_pop);
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);

    // The head is kept in its own register so it can hold its last value
    // after the FIFO drains, independent of stale storage entries.
    always_comb begin
        head_d = head_q;
        if (do_pop) begin
            if (count_q > (AW+1)'(1)) head_d = mem_q[rd_ptr_nxt];
            else if (do_push)         head_d = push_data_i;
        end else if (empty_o && do_push) begin
            head_d = push_data_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_pop)  rd_ptr_q <= rd_ptr_nxt;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign rd_data_o = head_q;
    assign count_o   = count_q;

endmodule

// File: rtl/serial_char_receiver.sv
// serial_char_receiver: 8N1 LSB-first asynchronous serial receiver.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   ena             block enable; low aborts any frame and parks in IDLE
//   rx              serial line (idle high)
//   rd_en           pop FIFO head
//   clr_err         clear sticky error flags
//   rd_data/valid   show-ahead FIFO head / non-empty
//   fifo_count      characters buffered
//   frame_err       sticky: stop bit sampled low
//   overrun         sticky: character dropped on full FIFO
//   chars_received  accepted-character counter (wraps)
//   which_state     FSM state code
module serial_char_receiver
    import serial_char_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [7:0]                    chars_received,
    output logic [3:0]                    which_state
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT/2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_sync_q;
    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           chars_q, chars_d;

    logic push, ferr_set, pop, full, empty, accept, ovr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
        if (!ena) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (!rx_sync_q) state_d = ST_START;
                end
                ST_START: begin
                    if (timer_q == HALF_M1) begin
                        timer_d   = '0;
                        bit_idx_d = '0;
                        state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
                    end
                end
                // Timer is now aligned to mid-bit, so each full wrap is a sample.
                ST_DATA: begin
                    if (timer_q == FULL_M1) begin
                        timer_d   = '0;
                        shreg_d   = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (timer_q == FULL_M1) begin
                        timer_d  = '0;
                        push     = rx_sync_q;
                        ferr_set = !rx_sync_q;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign pop     = rd_en && !empty;
    assign accept  = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    // A fresh error outranks a simultaneous clear.
    always_comb begin
        frame_err_d = ferr_set | (frame_err_q & ~clr_err);
        overrun_d   = ovr_set  | (overrun_q   & ~clr_err);
        chars_d     = accept ? chars_q + 8'd1 : chars_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            chars_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            chars_q     <= chars_d;
        end
    end

    char_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (shreg_q),
        .pop_i       (rd_en),
        .rd_data_o   (rd_data),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (fifo_count)
    );

    assign rd_valid       = !empty;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
    assign chars_received = chars_q;
    assign which_state    = state_q;

endmodule

// File: tb/tb_serial_char_receiver.sv
module tb_serial_char_receiver;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n, ena, rx, rd_en, clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic       frame_err, overrun;
    logic [7:0] chars_received;
    logic [3:0] which_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_char_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .rx             (rx),
        .rd_en          (rd_en),
        .clr_err        (clr_err),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .fifo_count     (fifo_count),
        .frame_err      (frame_err),
        .overrun        (overrun),
        .chars_received (chars_received),
        .which_state    (which_state)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       clr_before;
        logic       pop_at_push;
        logic       clr_at_push;
        logic [2:0] cnt;
        logic       valid;
        logic [7:0] head;
        logic [7:0] chars;
        logic       fe;
        logic       ov;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one full frame; returns one cycle before the push edge.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx = frame[b];
            repeat (CPB) tick();
        end
        rx = 1'b1;
    endtask

    task automatic apply_vec(input int i);
        if (vecs[i].clr_before) begin
            clr_err = 1'b1; tick(); clr_err = 1'b0;
        end
        send_byte(vecs[i].data, vecs[i].stop);
        rd_en   = vecs[i].pop_at_push;
        clr_err = vecs[i].clr_at_push;
        tick();
        rd_en   = 1'b0;
        clr_err = 1'b0;
        tick();
        chk($sformatf("v%0d count", i), 32'(fifo_count), 32'(vecs[i].cnt));
        chk($sformatf("v%0d valid", i), 32'(rd_valid), 32'(vecs[i].valid));
        chk($sformatf("v%0d head", i), 32'(rd_data), 32'(vecs[i].head));
        chk($sformatf("v%0d chars", i), 32'(chars_received), 32'(vecs[i].chars));
        chk($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(vecs[i].fe));
        chk($sformatf("v%0d overrun", i), 32'(overrun), 32'(vecs[i].ov));
    endtask

    task automatic pop_expect(input string nm, input logic [7:0] exp);
        chk(nm, 32'(rd_data), 32'(exp));
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    initial begin
        logic       saw_start;
        logic [7:0] burst [4];
        burst = '{8'h48, 8'h49, 8'h21, 8'h0A};

        //            data   stop  clrB  popP  clrP  cnt   vld   head   chars  fe    ov
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 8'h48, 8'd5,  1'b0, 1'b1};
        vecs[1] = '{8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 8'h49, 8'd6,  1'b0, 1'b0};
        vecs[2] = '{8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 8'h21, 8'd7,  1'b0, 1'b0};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 8'h21, 8'd7,  1'b1, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'h21, 8'd7,  1'b1, 1'b0};
        vecs[5] = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 8'h21, 8'd7,  1'b0, 1'b1};
        vecs[6] = '{8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'h0A, 8'd8,  1'b0, 1'b0};
        vecs[7] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 8'h11, 8'd9,  1'b0, 1'b0};
        vecs[8] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 8'h22, 8'd10, 1'b0, 1'b0};

        rst_n = 1'b0; ena = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        #1;
        chk("reset rd_data", 32'(rd_data), 32'h0);
        chk("reset state", 32'(which_state), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("idle state", 32'(which_state), 32'd0);
        chk("idle rd_valid", 32'(rd_valid), 32'd0);
        chk("idle chars", 32'(chars_received), 32'd0);
        chk("idle flags", 32'({frame_err, overrun}), 32'd0);

        // Single character with push latency
        send_byte(8'h41, 1'b1);
        chk("single pre state", 32'(which_state), 32'd3);
        chk("single pre valid", 32'(rd_valid), 32'd0);
        tick();
        chk("single valid", 32'(rd_valid), 32'd1);
        chk("single data", 32'(rd_data), 32'h41);
        chk("single chars", 32'(chars_received), 32'd1);
        chk("single state", 32'(which_state), 32'd0);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("single popped", 32'(rd_valid), 32'd0);

        // Back-to-back burst
        for (int i = 0; i < 4; i++) send_byte(burst[i], 1'b1);
        tick(); tick();
        chk("burst count", 32'(fifo_count), 32'd4);
        chk("burst chars", 32'(chars_received), 32'd5);

        for (int i = 0; i <= 6; i++) apply_vec(i);

        pop_expect("drain0", 8'h0A);
        pop_expect("drain1", 8'h66);
        pop_expect("drain2", 8'h77);
        pop_expect("drain3", 8'h34);
        chk("drained valid", 32'(rd_valid), 32'd0);
        chk("drained hold", 32'(rd_data), 32'h34);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("empty pop count", 32'(fifo_count), 32'd0);

        for (int i = 7; i <= 8; i++) apply_vec(i);
        rd_en = 1'b1; tick(); rd_en = 1'b0;

        // Glitch: one-cycle low pulse
        saw_start = 1'b0;
        rx = 1'b0; tick(); rx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (which_state == 4'd1) saw_start = 1'b1;
        end
        chk("glitch saw START", 32'(saw_start), 32'd1);
        chk("glitch state", 32'(which_state), 32'd0);
        chk("glitch flags", 32'({frame_err, overrun}), 32'd0);
        chk("glitch count", 32'(fifo_count), 32'd0);

        // Counter wrap: 246 more accepted characters take 10 -> 0
        for (int i = 0; i < 246; i++) begin
            send_byte(8'(i), 1'b1);
            tick(); tick();
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        chk("wrap chars", 32'(chars_received), 32'd0);
        chk("wrap count", 32'(fifo_count), 32'd0);

        // Abort mid-DATA with ena
        rx = 1'b0;
        repeat (8) tick();
        chk("abort in DATA", 32'(which_state), 32'd2);
        ena = 1'b0;
        tick();
        chk("abort state", 32'(which_state), 32'd0);
        rx = 1'b1;
        repeat (40) tick();
        ena = 1'b1;
        repeat (10) tick();
        chk("abort count", 32'(fifo_count), 32'd0);
        chk("abort flags", 32'({frame_err, overrun}), 32'd0);
        chk("abort chars", 32'(chars_received), 32'd0);
        send_byte(8'h3C, 1'b1);
        tick(); tick();
        chk("post-abort data", 32'(rd_data), 32'h3C);
        chk("post-abort chars", 32'(chars_received), 32'd1);

        // Asynchronous reset mid-frame
        rx = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        chk("rst state", 32'(which_state), 32'd0);
        chk("rst count", 32'(fifo_count), 32'd0);
        chk("rst chars", 32'(chars_received), 32'd0);
        chk("rst data", 32'(rd_data), 32'h0);
        rx = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
